// File: rtl/rdma_cmd_sched_pkg.sv
// Shared types and helpers for the read-DMA command scheduler.
// rr_pick is written for up to 16 requesters so the write-DMA side can reuse it.
package rdma_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_ISSUE  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int RR_MAX = 16;

  // Returns {found, index}: first set bit of req at or after ptr, wrapping modulo n.
  function automatic logic [4:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [3:0] ptr,
                                         input int n);
    logic       found;
    logic [3:0] idx;
    int         j;
    found = 1'b0;
    idx   = 4'd0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (i < n) begin
        // ptr < n and i < n, so a single subtraction wraps correctly for any n
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!found && req[j[3:0]]) begin
          found = 1'b1;
          idx   = j[3:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rdma_cmd_sched_rr_arbiter.sv
// Round-robin arbiter: combinational pick plus registered pointer.
// Optional build macro RDMA_SCHED_PRIO0_EN: requester 0 gets strict priority
// and its grants leave the round-robin pointer untouched.
module rr_arbiter
  import rdma_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_upd,
  input  logic [ID_BITS-1:0] i_upd_id,
  output logic               o_found,
  output logic [ID_BITS-1:0] o_win,
  output logic [ID_BITS-1:0] o_ptr
);

  logic [ID_BITS-1:0] r_ptr;
  logic [NUM_REQ-1:0] w_rr_req;
  logic [4:0]         w_pick;
  logic               w_upd_en;
  logic [ID_BITS-1:0] w_ptr_nxt;

  // Requests eligible for the round-robin search
  always_comb begin
    w_rr_req = i_req;
`ifdef RDMA_SCHED_PRIO0_EN
    w_rr_req[0] = 1'b0;
`endif
  end

  assign w_pick = rr_pick(RR_MAX'(w_rr_req), 4'(r_ptr), NUM_REQ);

  // Winner selection, requester 0 first when it has priority
  always_comb begin
    o_found = w_pick[4];
    o_win   = ID_BITS'(w_pick[3:0]);
`ifdef RDMA_SCHED_PRIO0_EN
    if (i_req[0]) begin
      o_found = 1'b1;
      o_win   = '0;
    end
`endif
  end

`ifdef RDMA_SCHED_PRIO0_EN
  assign w_upd_en = i_upd && (i_upd_id != '0);
`else
  assign w_upd_en = i_upd;
`endif

  // Pointer moves one past the finished owner; explicit wrap for non power-of-2 NUM_REQ
  assign w_ptr_nxt = (i_upd_id == ID_BITS'(NUM_REQ - 1)) ? '0 : i_upd_id + ID_BITS'(1);

  // Pointer register
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_ptr <= '0;
    else if (w_upd_en) r_ptr <= w_ptr_nxt;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/rdma_cmd_sched.sv
// Read-DMA command scheduler: arbitrates requesters onto one engine command
// port and holds the grant until the snooped output stream's tlast handshakes.
// Optional build macro RDMA_SCHED_PRIO0_EN (strict priority for requester 0).
module rdma_cmd_sched
  import rdma_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_BITS      = 2,
  parameter int ADDRESS_BITS = 32,
  parameter int LENGTH_BITS  = 32
) (
  input  logic                            i_aclk,
  input  logic                            i_areset,
  input  logic [NUM_REQ*ADDRESS_BITS-1:0] i_req_address,
  input  logic [NUM_REQ*LENGTH_BITS-1:0]  i_req_bytes,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [NUM_REQ-1:0]              o_req_done,
  output logic [ADDRESS_BITS-1:0]         o_rdma_cmd_address,
  output logic [LENGTH_BITS-1:0]          o_rdma_cmd_bytes,
  output logic                            o_rdma_cmd_valid,
  input  logic                            i_rdma_cmd_ready,
  input  logic                            i_mon_tvalid,
  input  logic                            i_mon_tready,
  input  logic                            i_mon_tlast,
  output logic [ID_BITS-1:0]              o_owner_id,
  output logic                            o_owner_valid
);

  state_t                  r_state, w_next;
  logic [ID_BITS-1:0]      r_owner;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [LENGTH_BITS-1:0]  r_bytes;
  logic                    w_found;
  logic [ID_BITS-1:0]      w_win;
  logic [ID_BITS-1:0]      w_ptr;
  logic                    w_last_beat;

  assign w_last_beat = i_mon_tvalid & i_mon_tready & i_mon_tlast;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_arb (
    .i_clk    (i_aclk),
    .i_rst    (i_areset),
    .i_req    (i_req_valid),
    .i_upd    (r_state == S_DONE),
    .i_upd_id (r_owner),
    .o_found  (w_found),
    .o_win    (w_win),
    .o_ptr    (w_ptr)
  );

  // Next state and Moore outputs decoded from the current state
  always_comb begin
    w_next           = r_state;
    o_req_ready      = '0;
    o_req_done       = '0;
    o_rdma_cmd_valid = 1'b0;
    o_owner_valid    = 1'b0;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_GRANT;
      S_GRANT: begin
        o_req_ready   = NUM_REQ'(1) << r_owner;
        o_owner_valid = 1'b1;
        w_next        = S_ISSUE;
      end
      S_ISSUE: begin
        o_rdma_cmd_valid = 1'b1;
        o_owner_valid    = 1'b1;
        // a zero-byte command produces no beats, so there is no tlast to wait for
        if (i_rdma_cmd_ready) w_next = (r_bytes == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        o_owner_valid = 1'b1;
        if (w_last_beat) w_next = S_DONE;
      end
      S_DONE: begin
        o_req_done = NUM_REQ'(1) << r_owner;
        w_next     = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // State, owner and latched command registers
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_addr  <= '0;
      r_bytes <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) r_owner <= w_win;
      if (r_state == S_GRANT) begin
        r_addr  <= i_req_address[r_owner*ADDRESS_BITS +: ADDRESS_BITS];
        r_bytes <= i_req_bytes[r_owner*LENGTH_BITS +: LENGTH_BITS];
      end
    end
  end

  assign o_rdma_cmd_address = r_addr;
  assign o_rdma_cmd_bytes   = r_bytes;
  assign o_owner_id         = r_owner;

endmodule
